// File: rtl/coh_pkg.sv
// Shared MSI coherence definitions for the bus-side snoop controller and the processor-side request FSM.
package coh_pkg;

  typedef enum logic [1:0] {
    ST_INVALID   = 2'b00,
    ST_EXCLUSIVE = 2'b01,
    ST_SHARED    = 2'b10
  } coh_state_t;

  typedef enum logic [1:0] {
    EMPTY_MESSAGE           = 2'b00,
    PLACE_READ_MISS_ON_BUS  = 2'b01,
    PLACE_INVALIDATE_ON_BUS = 2'b10,
    PLACE_WRITE_MISS_ON_BUS = 2'b11
  } bus_msg_t;

  typedef enum logic [1:0] {
    SNP_IDLE      = 2'b00,
    SNP_LOOKUP    = 2'b01,
    SNP_WRITEBACK = 2'b10
  } snoop_fsm_t;

  // The unused encoding 11 is stored as invalid.
  function automatic coh_state_t decode_state(input logic [1:0] raw);
    case (raw)
      2'b01:   return ST_EXCLUSIVE;
      2'b10:   return ST_SHARED;
      default: return ST_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/coh_state_table.sv
// Per-line coherence state and tag registers; processor writes take priority over snoop writes to the same line.
module coh_state_table
  import coh_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             proc_we,
  input  logic [IDX_W-1:0] proc_idx,
  input  logic [TAG_W-1:0] proc_tag,
  input  coh_state_t       proc_state,
  input  logic             snp_we,
  input  logic [IDX_W-1:0] snp_idx,
  input  coh_state_t       snp_state,
  input  logic [IDX_W-1:0] rd0_idx,
  output coh_state_t       rd0_state,
  output logic [TAG_W-1:0] rd0_tag,
  input  logic [IDX_W-1:0] rd1_idx,
  output coh_state_t       rd1_state,
  output logic [TAG_W-1:0] rd1_tag
);

  coh_state_t       state_q [NUM_LINES];
  logic [TAG_W-1:0] tag_q   [NUM_LINES];

  // A snoop only ever changes state; the tag belongs to the processor side.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        state_q[i] <= ST_INVALID;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (proc_we && (proc_idx == IDX_W'(i))) begin
          state_q[i] <= proc_state;
          tag_q[i]   <= proc_tag;
        end else if (snp_we && (snp_idx == IDX_W'(i))) begin
          state_q[i] <= snp_state;
        end
      end
    end
  end

  assign rd0_state = state_q[rd0_idx];
  assign rd0_tag   = tag_q[rd0_idx];
  assign rd1_state = state_q[rd1_idx];
  assign rd1_tag   = tag_q[rd1_idx];

endmodule

// File: rtl/snoop_bus_controller.sv
// MSI bus-side snoop controller: reacts to other caches' bus messages and issues write-backs of dirty lines.
// Optional SNOOP_PROTO_ERR_EN adds a sticky proto_err flag and a saturating err_count.
module snoop_bus_controller
  import coh_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             bus_valid,
  input  logic [1:0]       bus_msg,
  input  logic [IDX_W-1:0] bus_index,
  input  logic [TAG_W-1:0] bus_tag,
  output logic             snoop_ready,
  input  logic             proc_upd,
  input  logic [IDX_W-1:0] proc_index,
  input  logic [TAG_W-1:0] proc_tag,
  input  logic [1:0]       proc_state,
  output logic             snoop_hit,
  output logic             abort_mem,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_index,
  output logic [TAG_W-1:0] wb_tag,
  input  logic             wb_ack,
`ifdef SNOOP_PROTO_ERR_EN
  output logic             proto_err,
  output logic [7:0]       err_count,
`endif
  output logic             snoop_done
);

  snoop_fsm_t       fsm_q, fsm_d;
  bus_msg_t         cap_msg_q, cap_msg_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic [TAG_W-1:0] cap_tag_q, cap_tag_d;
  logic             hit_d, abort_d, done_d, wb_req_d;
  logic [IDX_W-1:0] wb_idx_d;
  logic [TAG_W-1:0] wb_tag_d;
  logic             snp_we;
  coh_state_t       snp_state;
  coh_state_t       lk_state, dbg_state;
  logic [TAG_W-1:0] lk_tag, dbg_tag;
  logic             lk_hit;
  logic             unused_dbg;

  coh_state_table #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_table (
    .clock      (clock),
    .reset_n    (reset_n),
    .proc_we    (proc_upd),
    .proc_idx   (proc_index),
    .proc_tag   (proc_tag),
    .proc_state (decode_state(proc_state)),
    .snp_we     (snp_we),
    .snp_idx    (cap_idx_q),
    .snp_state  (snp_state),
    .rd0_idx    (cap_idx_q),
    .rd0_state  (lk_state),
    .rd0_tag    (lk_tag),
    .rd1_idx    (proc_index),
    .rd1_state  (dbg_state),
    .rd1_tag    (dbg_tag)
  );

  assign unused_dbg = ^{dbg_state, dbg_tag};

  assign lk_hit = (lk_state != ST_INVALID) && (lk_tag == cap_tag_q) &&
                  (cap_msg_q != EMPTY_MESSAGE);
  assign snoop_ready = (fsm_q == SNP_IDLE);

  always_comb begin
    fsm_d     = fsm_q;
    cap_msg_d = cap_msg_q;
    cap_idx_d = cap_idx_q;
    cap_tag_d = cap_tag_q;
    hit_d     = 1'b0;
    abort_d   = 1'b0;
    done_d    = 1'b0;
    wb_req_d  = wb_req;
    wb_idx_d  = wb_index;
    wb_tag_d  = wb_tag;
    snp_we    = 1'b0;
    snp_state = ST_INVALID;
    case (fsm_q)
      SNP_IDLE: begin
        if (bus_valid) begin
          cap_msg_d = bus_msg_t'(bus_msg);
          cap_idx_d = bus_index;
          cap_tag_d = bus_tag;
          fsm_d     = SNP_LOOKUP;
        end
      end
      SNP_LOOKUP: begin
        fsm_d = SNP_IDLE;
        if (!lk_hit) begin
          done_d = 1'b1;
        end else if (lk_state == ST_SHARED) begin
          hit_d  = 1'b1;
          done_d = 1'b1;
          snp_we = (cap_msg_q != PLACE_READ_MISS_ON_BUS);
        end else if (cap_msg_q == PLACE_INVALIDATE_ON_BUS) begin
          // Invalidate against our own exclusive copy: drop it without a write-back.
          hit_d  = 1'b1;
          done_d = 1'b1;
          snp_we = 1'b1;
        end else begin
          hit_d     = 1'b1;
          abort_d   = 1'b1;
          wb_req_d  = 1'b1;
          wb_idx_d  = cap_idx_q;
          wb_tag_d  = lk_tag;
          snp_we    = 1'b1;
          snp_state = (cap_msg_q == PLACE_READ_MISS_ON_BUS) ? ST_SHARED : ST_INVALID;
          fsm_d     = SNP_WRITEBACK;
        end
      end
      SNP_WRITEBACK: begin
        if (wb_ack) begin
          wb_req_d = 1'b0;
          done_d   = 1'b1;
          fsm_d    = SNP_IDLE;
        end
      end
      default: fsm_d = SNP_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= SNP_IDLE;
      cap_msg_q  <= EMPTY_MESSAGE;
      cap_idx_q  <= '0;
      cap_tag_q  <= '0;
      snoop_hit  <= 1'b0;
      abort_mem  <= 1'b0;
      snoop_done <= 1'b0;
      wb_req     <= 1'b0;
      wb_index   <= '0;
      wb_tag     <= '0;
    end else begin
      fsm_q      <= fsm_d;
      cap_msg_q  <= cap_msg_d;
      cap_idx_q  <= cap_idx_d;
      cap_tag_q  <= cap_tag_d;
      snoop_hit  <= hit_d;
      abort_mem  <= abort_d;
      snoop_done <= done_d;
      wb_req     <= wb_req_d;
      wb_index   <= wb_idx_d;
      wb_tag     <= wb_tag_d;
    end
  end

`ifdef SNOOP_PROTO_ERR_EN
  logic viol;
  assign viol = ((fsm_q == SNP_LOOKUP) && lk_hit && (lk_state == ST_EXCLUSIVE) &&
                 (cap_msg_q == PLACE_INVALIDATE_ON_BUS)) ||
                (proc_upd && (proc_state == 2'b11));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
      err_count <= '0;
    end else if (viol) begin
      proto_err <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
